// File: rtl/dm_pkg.sv
// Shared encodings for the data-memory access path: request sizes, controller states,
// and the alignment rule used to reject bad requests before they touch memory.
package dm_pkg;

  localparam int DM_ADDR_W = 12;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_WRITE  = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  // The reserved size code is rejected the same way as a misaligned address.
  function automatic logic is_misaligned(size_e size, logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane handling: extracts and extends the loaded lane, and builds the
// merged word for a sub-word store.
module dm_lane_align
  import dm_pkg::*;
(
  input  size_e       size_i,
  input  logic        signed_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every output of a combinational block gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    byte_sel     = rd_word_i[{lane_i, 3'b000} +: 8];
    half_sel     = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    load_data_o  = rd_word_i;
    merge_data_o = wdata_i;

    case (size_i)
      SZ_BYTE: begin
        load_data_o  = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merge_data_o = rd_word_i;
        merge_data_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_data_o  = {{16{signed_i & half_sel[15]}}, half_sel};
        merge_data_o = lane_i[1] ? {wdata_i[15:0], rd_word_i[15:0]}
                                 : {rd_word_i[31:16], wdata_i[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller in front of the word-addressed data memory: byte/half/word
// accesses with sign/zero extension on loads and read-modify-write on sub-word stores.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              dm_we,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_din,
  input  logic [31:0]       dm_dout
);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  size_e               size_q, size_d;
  logic                signed_q, signed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         merge_q, merge_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         load_data;
  logic [31:0]         merge_data;

  // Request address bits above the memory window are intentionally discarded.
  logic                unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  dm_lane_align u_lane_align (
    .size_i       (size_q),
    .signed_i     (signed_q),
    .lane_i       (addr_q[1:0]),
    .rd_word_i    (dm_dout),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data),
    .merge_data_o (merge_data)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d     = req_we;
          size_d   = size_e'(req_size);
          signed_d = req_signed;
          addr_d   = req_addr[ADDR_W-1:0];
          wdata_d  = req_wdata;
          err_d    = is_misaligned(size_e'(req_size), req_addr[1:0]);
          state_d  = err_d ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end else if (size_q == SZ_WORD) begin
          state_d = ST_DONE;
        end else begin
          merge_d = merge_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      merge_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
    end
  end

  // Memory-side outputs depend only on registered state, never on the live request.
  always_comb begin
    dm_we  = 1'b0;
    dm_din = '0;
    case (state_q)
      ST_ACCESS: begin
        if (we_q && (size_q == SZ_WORD)) begin
          dm_we  = 1'b1;
          dm_din = wdata_q;
        end
      end
      ST_WRITE: begin
        dm_we  = 1'b1;
        dm_din = merge_q;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != ST_IDLE);
  assign ack     = (state_q == ST_DONE);
  assign err     = ack & err_q;
  assign rdata   = rdata_q;
  assign dm_addr = addr_q[ADDR_W-1:2];

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Load/store access controller between the CPU core and the 4 KB word-addressed data memory (dm_4k).
- Accepts byte, halfword and word load/store requests over a req/ack handshake.
- Performs little-endian lane extraction and sign/zero extension for loads.
- Performs read-modify-write for sub-word stores.
- Drives the data memory's we/addr/din and consumes its combinational dout.

Parameters:
ADDR_W, 12, byte-address bits used; dm_addr width is ADDR_W-2, and upper request address bits are ignored.

Ports:
clk  input  1  system clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req  input  1  request strobe, sampled only when busy=0
req_we  input  1  1=store, 0=load
req_size  input  2  00=byte, 01=half, 10=word, 11=reserved (treated as misaligned)
req_signed  input  1  loads only: 1=sign-extend, 0=zero-extend
req_addr  input  32  byte address; only [ADDR_W-1:0] used
req_wdata  input  32  store data, right-justified for byte/half
busy  output  1  high whenever state != IDLE
ack  output  1  one-cycle completion pulse
err  output  1  valid with ack; 1=misaligned/reserved, no memory access made
rdata  output  32  load result, updated at load completion and held until the next load completes
dm_we  output  1  data memory write enable
dm_addr  output  ADDR_W-2  word address = latched addr[ADDR_W-1:2]
dm_din  output  32  data memory write data
dm_dout  input  32  data memory combinational read data

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, ack=0, err=0, dm_we=0.
  - rdata=0; all latches=0.
  - Reset mid-transaction aborts it: no write occurs and no ack is issued.
- States are IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - On req=1, latch we/size/signed/addr/wdata.
  - Misaligned if size=01 and addr[0]=1, or size=10 and addr[1:0]!=0, or size=11. A misaligned request goes to DONE with err_q=1.
  - Otherwise the request goes to ACCESS with err_q=0.
- ACCESS (dm_addr driven from latch):
  - Load: rdata <= extracted lane. Byte lane is addr[1:0]; half lane is addr[1].
  - Load extension: sign-extend if signed=1, else zero-extend. Then go to DONE.
  - Word store: dm_we=1, dm_din=wdata, then go to DONE.
  - Sub-word store: merge_q <= dm_dout with the target lane replaced by wdata[7:0] or wdata[15:0]. Then go to WRITE.
- WRITE: dm_we=1, dm_din=merge_q; go to DONE.
- DONE:
  - ack=1 and err=err_q for exactly one cycle; go to IDLE.
  - A new req is accepted only in the following IDLE cycle.
- busy=0 only in IDLE. req while busy=1 is ignored, not queued.
- Latency, with req sampled at edge 0, counted until ack is high:
  - Misaligned: 1 cycle.
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
- dm_we is high only in ACCESS (word store) or WRITE, and never during load, err or IDLE.
- dm_we, dm_din and ack are decoded from registered state only; there are no combinational paths from req.
- Outside ACCESS/WRITE: dm_din=0; dm_addr continues to show the latched address.
- rdata is unchanged by stores and by err completions.
- Address wrap: upper bits are discarded, so 0x0000_1FFC accesses word 0x3FF.

Decomposition:
- Shared package (dm_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state encodings, DM_ADDR_W=12.
- Optional sub-module dm_lane_align (purely combinational):
  - Load path: extract and extend.
  - Store path: merge.
- The FSM and registers stay in dm_access_ctrl.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x010, then load word at 0x010.
  - Store: ack at cycle 2, dm_we pulsed once, dm_addr=0x004.
  - Load: rdata=0xDEADBEEF, err=0.
- Byte store RMW: memory word 0x11223344 at 0x020; store byte 0xAA to 0x022.
  - 3-cycle latency; the single write is 0x11AA3344.
- Load extension on word 0x80FF7F01 at 0x030:
  - lb 0x032 signed -> 0xFFFFFFFF.
  - lbu 0x031 -> 0x0000007F.
  - lh 0x032 signed -> 0xFFFF80FF.
  - lhu 0x030 -> 0x00007F01.
- Misaligned: lw 0x005 and sh 0x003.
  - Each acks at cycle 1 with err=1, dm_we never high, rdata unchanged.
- Busy/backpressure: assert req continuously with differing requests during a byte store.
  - Only the first is serviced; the next is accepted in the IDLE cycle after ack.
- Reset mid-op: drop rst_n during WRITE of a byte store.
  - dm_we falls immediately, memory is unchanged, no ack, busy=0, rdata=0.
